// File: rtl/wimax_interleaver.sv
// 802.16 OFDM bit interleaver: serial coded bits in, each NCBPS-bit block out in permuted order.
// Ping-pong banks let block N+1 be written while block N is read out.
module wimax_interleaver #(
    parameter int unsigned NCBPS  = 192,
    parameter int unsigned NCPC   = 2,
    parameter int unsigned D      = 16,
    parameter int unsigned ADDR_W = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic input_data,
    input  logic data_valid,
    input  logic ready_in,
    output logic output_data,
    output logic valid_out,
    output logic ready_out
);

    localparam int unsigned ROWS = NCBPS / D;
    localparam int unsigned S    = (NCPC / 2 > 1) ? NCPC / 2 : 1;
    localparam int unsigned CW   = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IW   = $clog2(NCBPS);

    logic mem [2*NCBPS];

    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [IW-1:0]     m_q;
    logic              wbank_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic [1:0]        full_eff;
    logic              rbank_q;
    logic [IW-1:0]     rd_idx_q;

    logic              accept;
    logic              wr_done;
    logic              rd_adv;
    logic              rd_done;
    logic [IW-1:0]     j;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              load;
    logic              load_bank;
    logic [IW-1:0]     load_idx;

    assign ready_out = !full_q[wbank_q];
    assign accept    = data_valid && ready_out;
    assign wr_done   = accept && (col_q == CW'(D - 1)) && (row_q == RW'(ROWS - 1));
    assign rd_adv    = valid_out && ready_in;
    assign rd_done   = rd_adv && (rd_idx_q == IW'(NCBPS - 1));

    // A bank completing this cycle is already readable, so readout starts without a bubble.
    assign full_eff = full_q | ({1'b0, wr_done} << wbank_q);

    // m is tracked incrementally; floor(D*m/NCBPS) equals the column index, so no divider.
    assign j = IW'(S * (32'(m_q) / S) + (32'(m_q) + NCBPS - 32'(col_q)) % S);

    assign wr_addr = wbank_q ? ADDR_W'(NCBPS) + ADDR_W'(j) : ADDR_W'(j);
    assign rd_addr = load_bank ? ADDR_W'(NCBPS) + ADDR_W'(load_idx) : ADDR_W'(load_idx);

    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wbank_q] = 1'b1;
        if (rd_done) full_d[rbank_q] = 1'b0;
    end

    always_comb begin
        load      = 1'b0;
        load_bank = rbank_q;
        load_idx  = '0;
        if (rd_done) begin
            load_bank = ~rbank_q;
            load      = full_eff[~rbank_q];
        end else if (rd_adv) begin
            load     = 1'b1;
            load_idx = rd_idx_q + IW'(1);
        end else if (!valid_out) begin
            load = full_eff[rbank_q];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_addr] <= input_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            m_q         <= '0;
            wbank_q     <= 1'b0;
            full_q      <= '0;
            rbank_q     <= 1'b0;
            rd_idx_q    <= '0;
            output_data <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                if (wr_done) begin
                    col_q   <= '0;
                    row_q   <= '0;
                    m_q     <= '0;
                    wbank_q <= ~wbank_q;
                end else if (col_q == CW'(D - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                    m_q   <= IW'(row_q) + IW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                    m_q   <= m_q + IW'(ROWS);
                end
            end
            if (rd_done) rbank_q <= ~rbank_q;
            if (load) begin
                output_data <= mem[rd_addr];
                valid_out   <= 1'b1;
                rd_idx_q    <= load_idx;
            end else if (rd_done) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wimax_interleaver.sv
// Directed bench for wimax_interleaver: known-answer block, streaming, backpressure, full buffer,
// mid-block reset and a one-hot permutation sweep.
module tb_wimax_interleaver;

    localparam int N = 192;

    logic clk = 1'b0;
    logic reset;
    logic input_data;
    logic data_valid;
    logic ready_in;
    logic output_data;
    logic valid_out;
    logic ready_out;

    logic [N-1:0] din_v;
    logic [N-1:0] dout_v;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wimax_interleaver #(
        .NCBPS (192),
        .NCPC  (2),
        .D     (16),
        .ADDR_W(9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .input_data (input_data),
        .data_valid (data_valid),
        .ready_in   (ready_in),
        .output_data(output_data),
        .valid_out  (valid_out),
        .ready_out  (ready_out)
    );

    task automatic apply_reset();
        reset      = 1'b0;
        data_valid = 1'b0;
        input_data = 1'b0;
        ready_in   = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        data_valid = 1'b0;
        input_data = 1'b0;
        ready_in   = 1'b1;
        #1;
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid_out: got %b want 0", valid_out);
        end
        vectors++;
        if (output_data !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_output_data: got %b want 0", output_data);
        end
        vectors++;
        if (ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_out: got %b want 1", ready_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_idle: valid_out=%b ready_out=%b want 0/1", valid_out, ready_out);
        end
    endtask

    task automatic test_single_block();
        int ii, oi;
        bit done_prev;
        apply_reset();
        ii = 0; oi = 0; done_prev = 1'b0;
        for (int cyc = 0; cyc < 3 * N && oi < N; cyc++) begin
            if (done_prev) begin
                vectors++;
                if (valid_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_latency: valid_out=%b want 1 after last input", valid_out);
                end
                done_prev = 1'b0;
            end
            if (valid_out === 1'b1) begin
                vectors++;
                if (ii < N || output_data !== dout_v[N-1-oi]) begin
                    miscompares++;
                    $display("FAIL single_bit %0d: got %b want %b (inputs sent %0d)", oi, output_data,
                             dout_v[N-1-oi], ii);
                end
                oi++;
            end else if (oi > 0) begin
                vectors++;
                miscompares++;
                $display("FAIL single_gap at bit %0d: valid_out=%b want 1", oi, valid_out);
            end
            if (ii < N) begin
                data_valid = 1'b1;
                input_data = din_v[N-1-ii];
                ii++;
                done_prev = (ii == N);
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        vectors++;
        if (oi != N) begin
            miscompares++;
            $display("FAIL single_count: got %0d bits want %0d", oi, N);
        end
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_tail: valid_out=%b want 0", valid_out);
        end
    endtask

    task automatic test_back_to_back();
        int ii, oi;
        apply_reset();
        ii = 0; oi = 0;
        for (int cyc = 0; cyc < 5 * N && oi < 2 * N; cyc++) begin
            if (valid_out === 1'b1) begin
                vectors++;
                if (ii < N || output_data !== dout_v[N-1-(oi%N)]) begin
                    miscompares++;
                    $display("FAIL b2b_bit %0d: got %b want %b", oi, output_data, dout_v[N-1-(oi%N)]);
                end
                oi++;
            end else if (oi > 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_gap at bit %0d: valid_out=%b want 1", oi, valid_out);
            end
            if (ii < 2 * N) begin
                vectors++;
                if (ready_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready_out at input %0d: got %b want 1", ii, ready_out);
                end
                data_valid = 1'b1;
                input_data = din_v[N-1-(ii%N)];
                ii++;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        vectors++;
        if (oi != 2 * N) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d bits want %0d", oi, 2 * N);
        end
    endtask

    task automatic test_backpressure();
        int oi;
        bit held;
        logic hold_bit;
        apply_reset();
        for (int ii = 0; ii < N; ii++) begin
            data_valid = 1'b1;
            input_data = din_v[N-1-ii];
            @(negedge clk);
        end
        data_valid = 1'b0;
        oi = 0; held = 1'b0; hold_bit = 1'b0;
        for (int cyc = 0; cyc < 20 * N && oi < N; cyc++) begin
            ready_in = 1'($urandom_range(0, 1));
            if (held) begin
                vectors++;
                if (valid_out !== 1'b1 || output_data !== hold_bit) begin
                    miscompares++;
                    $display("FAIL bp_hold bit %0d: valid_out=%b data=%b want 1/%b", oi, valid_out,
                             output_data, hold_bit);
                end
            end
            if (valid_out === 1'b1) begin
                if (ready_in) begin
                    vectors++;
                    if (output_data !== dout_v[N-1-oi]) begin
                        miscompares++;
                        $display("FAIL bp_bit %0d: got %b want %b", oi, output_data, dout_v[N-1-oi]);
                    end
                    oi++;
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    hold_bit = dout_v[N-1-oi];
                end
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL bp_valid_drop at bit %0d: valid_out=%b want 1", oi, valid_out);
            end
            @(negedge clk);
        end
        ready_in = 1'b1;
        vectors++;
        if (oi != N) begin
            miscompares++;
            $display("FAIL bp_count: got %0d bits want %0d", oi, N);
        end
    endtask

    task automatic test_buffer_full();
        int oi;
        apply_reset();
        ready_in = 1'b0;
        for (int ii = 0; ii < 2 * N; ii++) begin
            vectors++;
            if (ready_out !== 1'b1) begin
                miscompares++;
                $display("FAIL full_ready_early at input %0d: got %b want 1", ii, ready_out);
            end
            data_valid = 1'b1;
            input_data = din_v[N-1-(ii%N)];
            @(negedge clk);
        end
        vectors++;
        if (ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready_out: got %b want 0", ready_out);
        end
        vectors++;
        if (valid_out !== 1'b1 || output_data !== dout_v[N-1]) begin
            miscompares++;
            $display("FAIL full_hold: valid_out=%b data=%b want 1/%b", valid_out, output_data, dout_v[N-1]);
        end
        // Junk presented while full must be dropped.
        for (int g = 0; g < 4; g++) begin
            input_data = 1'(g);
            @(negedge clk);
        end
        data_valid = 1'b0;
        ready_in = 1'b1;
        oi = 0;
        for (int cyc = 0; cyc < 5 * N && oi < 2 * N; cyc++) begin
            if (valid_out === 1'b1) begin
                vectors++;
                if (output_data !== dout_v[N-1-(oi%N)]) begin
                    miscompares++;
                    $display("FAIL full_bit %0d: got %b want %b", oi, output_data, dout_v[N-1-(oi%N)]);
                end
                oi++;
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL full_gap at bit %0d: valid_out=%b want 1", oi, valid_out);
            end
            @(negedge clk);
        end
        vectors++;
        if (oi != 2 * N || ready_out !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL full_recover: bits=%0d ready_out=%b valid_out=%b want %0d/1/0", oi, ready_out,
                     valid_out, 2 * N);
        end
    endtask

    task automatic test_reset_mid_block();
        int oi;
        apply_reset();
        ready_in = 1'b0;
        for (int ii = 0; ii < N; ii++) begin
            data_valid = 1'b1;
            input_data = din_v[N-1-ii];
            @(negedge clk);
        end
        // Let one output bit go so the held bit is a 1, then stall and write 100 more bits.
        for (int ii = 0; ii < 100; ii++) begin
            ready_in   = (ii == 0);
            input_data = din_v[N-1-ii];
            @(negedge clk);
        end
        data_valid = 1'b0;
        vectors++;
        if (valid_out !== 1'b1 || output_data !== dout_v[N-2]) begin
            miscompares++;
            $display("FAIL rst_pre: valid_out=%b data=%b want 1/%b", valid_out, output_data, dout_v[N-2]);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (valid_out !== 1'b0 || output_data !== 1'b0 || ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async: valid_out=%b data=%b ready_out=%b want 0/0/1", valid_out,
                     output_data, ready_out);
        end
        @(negedge clk);
        reset    = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        for (int ii = 0; ii < N; ii++) begin
            data_valid = 1'b1;
            input_data = din_v[N-1-ii];
            @(negedge clk);
        end
        data_valid = 1'b0;
        oi = 0;
        for (int cyc = 0; cyc < N + 4; cyc++) begin
            if (oi < N) begin
                vectors++;
                if (valid_out !== 1'b1 || output_data !== dout_v[N-1-oi]) begin
                    miscompares++;
                    $display("FAIL rst_fresh_bit %0d: valid_out=%b data=%b want 1/%b", oi, valid_out,
                             output_data, dout_v[N-1-oi]);
                end
                oi++;
            end else begin
                vectors++;
                if (valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rst_stale_block: valid_out=%b want 0", valid_out);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_permutation_sweep();
        int ii, oi, ob, jk;
        logic [N-1:0] cap;
        logic [N-1:0] exp_v;
        apply_reset();
        ii = 0; oi = 0;
        cap = '0;
        for (int cyc = 0; cyc < N * N + 4 * N && oi < N * N; cyc++) begin
            if (valid_out === 1'b1) begin
                cap[oi%N] = output_data;
                if (oi % N == N - 1) begin
                    ob    = oi / N;
                    jk    = 12 * (ob % 16) + ob / 16;
                    exp_v = '0;
                    exp_v[jk] = 1'b1;
                    vectors++;
                    if (cap !== exp_v) begin
                        miscompares++;
                        $display("FAIL sweep k=%0d: got %h want %h", ob, cap, exp_v);
                    end
                end
                oi++;
            end
            if (ii < N * N) begin
                data_valid = 1'b1;
                input_data = ((ii % N) == (ii / N));
                ii++;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        vectors++;
        if (oi != N * N) begin
            miscompares++;
            $display("FAIL sweep_count: got %0d bits want %0d", oi, N * N);
        end
    endtask

    initial begin
        din_v  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
        dout_v = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_buffer_full();
        test_reset_mid_block();
        test_permutation_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
